// File: rtl/seq_scan_ctrl.sv
// Word-to-serial front end for a programmable overlapping-pattern detector.
// Accepts a word, shifts it MSB-first through the detector, and reports match count and first match index.
module seq_scan_ctrl #(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int IDX_W   = $clog2(DATA_W),
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_continue,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic [IDX_W-1:0]   out_first_idx,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  state_t state, state_n;

  // A length of zero or anything above PAT_MAX selects the full pattern.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if ((len == '0) || (int'(len) > PAT_MAX)) return LEN_W'(PAT_MAX);
    return len;
  endfunction

  function automatic logic [LEN_W-1:0] sat_seen(input logic [LEN_W-1:0] s);
    if (int'(s) >= PAT_MAX) return LEN_W'(PAT_MAX);
    return s + LEN_W'(1);
  endfunction

  function automatic logic [PAT_MAX-1:0] len_to_mask(input logic [LEN_W-1:0] len);
    logic [PAT_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_MAX; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  logic [DATA_W-1:0]  word_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;

  logic [PAT_MAX-1:0] hist;
  logic [LEN_W-1:0]   seen;
  logic [IDX_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   first_idx;
  logic               found;

  logic               cur_bit;
  logic [PAT_MAX-1:0] hist_n;
  logic [LEN_W-1:0]   seen_n;
  logic [PAT_MAX-1:0] len_mask;
  logic               match;
  logic               accept;
  logic               last_bit;

  assign accept   = in_valid & in_ready;
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));

  // Detector: next history and Mealy match on the bit being shifted this cycle
  assign cur_bit  = word_q[DATA_W-1];
  assign hist_n   = (hist << 1) | PAT_MAX'(cur_bit);
  assign seen_n   = sat_seen(seen);
  assign len_mask = len_to_mask(len_q);
  assign match    = (state == SHIFT) && (seen_n >= len_q) &&
                    (((hist_n ^ pat_q) & len_mask) == '0);

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_n = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state: FSM, detector history and match statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hist      <= '0;
      seen      <= '0;
      bit_idx   <= '0;
      count     <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        bit_idx   <= '0;
        count     <= '0;
        first_idx <= '0;
        found     <= 1'b0;
        // Stream mode keeps history so boundary-spanning matches land in the next word.
        if (!cfg_continue) begin
          hist <= '0;
          seen <= '0;
        end
      end else if (state == SHIFT) begin
        bit_idx <= bit_idx + IDX_W'(1);
        hist    <= hist_n;
        seen    <= seen_n;
        if (match) begin
          count <= count + CNT_W'(1);
          if (!found) begin
            first_idx <= bit_idx;
            found     <= 1'b1;
          end
        end
      end
    end
  end

  // Datapath: word and configuration captured at accept, word shifted MSB-first
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= in_data;
      pat_q  <= cfg_pattern;
      len_q  <= clamp_len(cfg_len);
    end else if (state == SHIFT) begin
      word_q <= word_q << 1;
    end
  end

  assign out_count     = count;
  assign out_first_idx = first_idx;

endmodule
